// File: rtl/noc_pkg.sv
// Shared NoC definitions: local port index, injector FSM states and the default flit layout.
package noc_pkg;

  localparam int LOCAL_PORT  = 0;
  localparam int FLIT_DATA_W = 64;
  localparam int FLIT_DEST_W = 6;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } inj_state_t;

  typedef struct packed {
    logic [FLIT_DATA_W-1:0] data;
    logic [FLIT_DEST_W-1:0] dest;
    logic                   is_tail;
  } flit_t;

endpackage

// File: rtl/flit_skid_buffer.sv
// Two-entry fall-through skid buffer with a registered ready; an empty buffer
// hands an incoming beat straight to the output in the same cycle.
module flit_skid_buffer
  import noc_pkg::*;
#(
  parameter type T = flit_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T           mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       push;
  logic       pop;
  logic       pop_mem;
  logic       store;

  assign push      = in_valid & in_ready;
  assign out_valid = (count != 2'd0) | push;
  assign out_data  = (count == 2'd0) ? in_data : mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign pop_mem   = pop & (count != 2'd0);
  // a beat popped in its arrival cycle never touches storage
  assign store     = push & ~(pop & (count == 2'd0));

  always_comb begin
    count_next = count + {1'b0, store} - {1'b0, pop_mem};
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      if (store)   wr_ptr <= ~wr_ptr;
      if (pop_mem) rd_ptr <= ~rd_ptr;
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
    end
  end

endmodule

// File: rtl/axis_flit_injector.sv
// AXI-Stream to credit-based wormhole flit injector for the router local port.
// Optional flit/packet counters are enabled by AXIS_FLIT_INJECTOR_STATS_EN.
//   state | meaning
//   HEAD  | next flit opens a packet and carries its own {tid, tdest}
//   BODY  | mid-packet, flits carry the destination latched from the head
module axis_flit_injector
  import noc_pkg::*;
#(
  parameter int TDATA_WIDTH       = 64,
  parameter int TDEST_WIDTH       = 4,
  parameter int TID_WIDTH         = 2,
  parameter int DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc_sync,
  input  logic                    axis_in_tvalid,
  output logic                    axis_in_tready,
  input  logic [TDATA_WIDTH-1:0]  axis_in_tdata,
  input  logic                    axis_in_tlast,
  input  logic [TID_WIDTH-1:0]    axis_in_tid,
  input  logic [TDEST_WIDTH-1:0]  axis_in_tdest,
  output logic [TDATA_WIDTH-1:0]  data_out,
  output logic [DEST_WIDTH-1:0]   dest_out,
  output logic                    is_tail_out,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credits_avail,
  output logic                    credit_err
`ifdef AXIS_FLIT_INJECTOR_STATS_EN
  ,
  output logic [31:0]             flit_count,
  output logic [31:0]             pkt_count
`endif
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0]  dest;
    logic                   is_tail;
  } inj_flit_t;

  inj_flit_t              in_flit;
  inj_flit_t              head_flit;
  logic                   head_valid;
  logic                   send;
  inj_state_t             state_q;
  inj_state_t             state_d;
  logic [DEST_WIDTH-1:0]  dest_lock;
  logic [DEST_WIDTH-1:0]  flit_dest;

  assign in_flit = {axis_in_tdata, axis_in_tid, axis_in_tdest, axis_in_tlast};

  flit_skid_buffer #(
    .T (inj_flit_t)
  ) u_skid (
    .clk       (clk_noc),
    .rst       (rst_noc_sync),
    .in_valid  (axis_in_tvalid),
    .in_ready  (axis_in_tready),
    .in_data   (in_flit),
    .out_valid (head_valid),
    .out_ready (send),
    .out_data  (head_flit)
  );

  // credits are registered, so a returned credit can only enable the next cycle's send
  assign send = head_valid & (credits_avail != '0);

  always_comb begin
    state_d   = state_q;
    flit_dest = dest_lock;
    case (state_q)
      HEAD: begin
        flit_dest = head_flit.dest;
        if (send && !head_flit.is_tail) state_d = BODY;
      end
      BODY: begin
        if (send && head_flit.is_tail) state_d = HEAD;
      end
      default: state_d = HEAD;
    endcase
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q     <= HEAD;
      dest_lock   <= '0;
      send_out    <= 1'b0;
      is_tail_out <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
    end else begin
      state_q  <= state_d;
      send_out <= send;
      if (send) begin
        data_out    <= head_flit.data;
        dest_out    <= flit_dest;
        is_tail_out <= head_flit.is_tail;
      end else begin
        is_tail_out <= 1'b0;
      end
      if (send && state_q == HEAD) dest_lock <= head_flit.dest;
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      credits_avail <= CREDIT_MAX;
      credit_err    <= 1'b0;
    end else begin
      case ({send, credit_in})
        2'b10: credits_avail <= credits_avail - 1'b1;
        2'b01: begin
          // a credit with the downstream FIFO already empty means the link lost sync
          if (credits_avail == CREDIT_MAX) credit_err <= 1'b1;
          else                             credits_avail <= credits_avail + 1'b1;
        end
        default: credits_avail <= credits_avail;
      endcase
    end
  end

`ifdef AXIS_FLIT_INJECTOR_STATS_EN
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      flit_count <= '0;
      pkt_count  <= '0;
    end else if (send) begin
      flit_count <= flit_count + 32'd1;
      if (head_flit.is_tail) pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_flit_injector.sv
// Scoreboard bench for axis_flit_injector: directed scenarios plus randomized packets.
module tb_axis_flit_injector;

  localparam int DW    = 64;
  localparam int TDW   = 4;
  localparam int TIW   = 2;
  localparam int DSW   = TDW + TIW;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic           clk_noc = 1'b0;
  logic           rst_noc_sync = 1'b1;
  logic           axis_in_tvalid = 1'b0;
  logic           axis_in_tready;
  logic [DW-1:0]  axis_in_tdata = '0;
  logic           axis_in_tlast = 1'b0;
  logic [TIW-1:0] axis_in_tid = '0;
  logic [TDW-1:0] axis_in_tdest = '0;
  logic [DW-1:0]  data_out;
  logic [DSW-1:0] dest_out;
  logic           is_tail_out;
  logic           send_out;
  logic           credit_in = 1'b0;
  logic [CW-1:0]  credits_avail;
  logic           credit_err;
`ifdef AXIS_FLIT_INJECTOR_STATS_EN
  logic [31:0]    flit_count;
  logic [31:0]    pkt_count;
`endif

  axis_flit_injector dut (
    .clk_noc        (clk_noc),
    .rst_noc_sync   (rst_noc_sync),
    .axis_in_tvalid (axis_in_tvalid),
    .axis_in_tready (axis_in_tready),
    .axis_in_tdata  (axis_in_tdata),
    .axis_in_tlast  (axis_in_tlast),
    .axis_in_tid    (axis_in_tid),
    .axis_in_tdest  (axis_in_tdest),
    .data_out       (data_out),
    .dest_out       (dest_out),
    .is_tail_out    (is_tail_out),
    .send_out       (send_out),
    .credit_in      (credit_in),
    .credits_avail  (credits_avail),
    .credit_err     (credit_err)
`ifdef AXIS_FLIT_INJECTOR_STATS_EN
    ,
    .flit_count     (flit_count),
    .pkt_count      (pkt_count)
`endif
  );

  always #5 clk_noc = ~clk_noc;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [DSW-1:0] dest;
    logic           tail;
  } exp_t;

  exp_t           exp_q[$];
  int             errors = 0;
  int             checks = 0;
  int             sent_total = 0;
  int             returned_total = 0;
  bit             auto_credit = 1'b0;
  bit             man_credit = 1'b0;
  bit             in_pkt = 1'b0;
  logic [DSW-1:0] lock_dest = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every flit and tracks credits arithmetically.
  int             exp_cred = DEPTH;
  bit             exp_err = 1'b0;
  bit             prev_rst = 1'b1;
  logic [DW-1:0]  last_data = '0;
  logic [DSW-1:0] last_dest = '0;

  always @(negedge clk_noc) begin
    exp_t e;
    if (rst_noc_sync) begin
      chk("rst_send_out", send_out, 0);
      chk("rst_tready", axis_in_tready, 0);
      chk("rst_credits", credits_avail, DEPTH);
      chk("rst_credit_err", credit_err, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_dest_out", dest_out, 0);
      chk("rst_is_tail", is_tail_out, 0);
      exp_cred   = DEPTH;
      exp_err    = 1'b0;
      sent_total = 0;
      last_data  = '0;
      last_dest  = '0;
    end else begin
      if (prev_rst) chk("tready_after_rst", axis_in_tready, 1);
      if (send_out) begin
        sent_total++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_send: got flit data=%0h with nothing expected", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("flit_data", data_out, e.data);
          chk("flit_dest", dest_out, e.dest);
          chk("flit_tail", is_tail_out, e.tail);
        end
        last_data = data_out;
        last_dest = dest_out;
      end else begin
        chk("hold_data", data_out, last_data);
        chk("hold_dest", dest_out, last_dest);
      end
      exp_cred = exp_cred - (send_out ? 1 : 0) + (credit_in ? 1 : 0);
      if (exp_cred > DEPTH) begin
        exp_cred = DEPTH;
        exp_err  = 1'b1;
      end
      chk("credits", credits_avail, exp_cred);
      chk("credit_err", credit_err, exp_err);
    end
    prev_rst = rst_noc_sync;
  end

  // Downstream model: returns credits for delivered flits, plus explicit one-shot pulses.
  always @(negedge clk_noc) begin
    #2;
    if (rst_noc_sync) begin
      credit_in      = 1'b0;
      returned_total = 0;
      man_credit     = 1'b0;
    end else if (man_credit) begin
      credit_in  = 1'b1;
      man_credit = 1'b0;
      returned_total++;
    end else if (auto_credit && sent_total > returned_total && $urandom_range(0, 2) != 0) begin
      credit_in = 1'b1;
      returned_total++;
    end else begin
      credit_in = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk_noc);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [TIW-1:0] id,
                           input logic [TDW-1:0] td, input logic last);
    exp_t e;
    int   waits = 0;
    axis_in_tvalid = 1'b1;
    axis_in_tdata  = d;
    axis_in_tid    = id;
    axis_in_tdest  = td;
    axis_in_tlast  = last;
    while (!axis_in_tready && waits < 300) begin
      tick();
      waits++;
    end
    if (!axis_in_tready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got tready=0 for %0d cycles, required 1", waits);
      axis_in_tvalid = 1'b0;
      return;
    end
    e.data = d;
    e.tail = last;
    if (!in_pkt) begin
      e.dest    = {id, td};
      lock_dest = e.dest;
    end else begin
      e.dest = lock_dest;
    end
    in_pkt = !last;
    exp_q.push_back(e);
    tick();
    axis_in_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    auto_credit = 1'b1;
    while ((exp_q.size() != 0 || sent_total != returned_total || credits_avail != CW'(DEPTH))
           && n < 1000) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_credits", credits_avail, DEPTH);
    auto_credit = 1'b0;
    tick();
  endtask

  task automatic do_reset(input int cycles);
    rst_noc_sync   = 1'b1;
    axis_in_tvalid = 1'b0;
    exp_q.delete();
    in_pkt = 1'b0;
    repeat (cycles) tick();
    rst_noc_sync = 1'b0;
    tick();
  endtask

  initial begin
    int base;
    int len;
    #600000;
    $display("FAIL watchdog: got no finish by %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int len;
    repeat (3) tick();
    rst_noc_sync = 1'b0;
    tick();

    // 3-beat packet tid=1 tdest=5, no credit returns
    send_beat(64'hA000_0001, 2'd1, 4'd5, 1'b0);
    chk("first_flit_latency", send_out, 1);
    send_beat(64'hA000_0002, 2'd1, 4'd5, 1'b0);
    send_beat(64'hA000_0003, 2'd1, 4'd5, 1'b1);
    tick();
    chk("pkt1_dest", dest_out, 6'h15);
    chk("pkt1_credits_5", credits_avail, 5);

    // body flit ignores its own tdest
    send_beat(64'hB000_0001, 2'd0, 4'd2, 1'b0);
    send_beat(64'hB000_0002, 2'd0, 4'd7, 1'b1);
    tick();
    chk("body_dest_locked", dest_out, 6'h02);
    chk("pkt2_credits_3", credits_avail, 3);

    // send and credit in the same cycle at credits=3
    man_credit = 1'b1;
    send_beat(64'hC000_0001, 2'd2, 4'd1, 1'b1);
    chk("send_plus_credit", credits_avail, 3);
    drain();

    // credit exhaustion with 10 single-flit packets
    base = sent_total;
    for (int i = 0; i < 10; i++) send_beat(64'hD000_0000 + 64'(i), 2'(i), 4'(i), 1'b1);
    repeat (3) tick();
    chk("exhaust_sends_8", sent_total - base, 8);
    chk("exhaust_tready_low", axis_in_tready, 0);
    chk("exhaust_held_2", exp_q.size(), 2);
    man_credit = 1'b1;
    tick();
    tick();
    chk("one_credit_one_send", sent_total - base, 9);
    repeat (3) tick();
    chk("only_one_extra_send", sent_total - base, 9);
    drain();

    // reset in the middle of a 4-beat packet
    auto_credit = 1'b1;
    send_beat(64'hE000_0001, 2'd3, 4'd9, 1'b0);
    send_beat(64'hE000_0002, 2'd3, 4'd9, 1'b0);
    do_reset(2);
    chk("post_rst_credits", credits_avail, DEPTH);
    send_beat(64'hF000_0001, 2'd2, 4'd4, 1'b0);
    chk("post_rst_head_dest", dest_out, 6'h24);
    send_beat(64'hF000_0002, 2'd1, 4'd1, 1'b1);
    drain();

    // randomized packets with random downstream credit returns
    auto_credit = 1'b1;
    for (int p = 0; p < 80; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        send_beat({$urandom, $urandom}, TIW'($urandom), TDW'($urandom), b == len - 1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      end
    end
    drain();

    // credit overflow is sticky until reset
    man_credit = 1'b1;
    tick();
    tick();
    chk("overflow_err_set", credit_err, 1);
    chk("overflow_saturate", credits_avail, DEPTH);
    repeat (3) tick();
    chk("overflow_err_sticky", credit_err, 1);
    do_reset(2);
    chk("err_cleared_by_rst", credit_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
